// File: rtl/clock_group_reset_sequencer.sv
// clock_group_reset_sequencer
//
// Sequences synchronous resets for a group of clock-domain members that
// share one clock. After reset every member is held in reset for HOLD_CYCLES.
// The enabled members are then released one at a time in ascending index
// order, GAP_CYCLES apart. A request to re-enter reset asserts the member
// resets again in descending order before the group returns to HOLD.
//
// Ports
//   clock            single clock for all logic
//   reset            synchronous, active-high reset
//   io_member_en     per-member enable mask; a 0 keeps that member in reset
//   io_req_assert    level request to re-enter reset, sampled every cycle
//   io_out_reset     per-member active-high synchronous reset (registered)
//   io_out_clock_en  per-member clock enable (registered)
//   io_state         FSM state: 0 HOLD, 1 RELEASE, 2 RUN, 3 QUIESCE
//   io_busy          high whenever the FSM is not in RUN
//   io_done          one-cycle pulse on the cycle RUN is entered
//
// Every output comes from a flop. The next-state logic reads the inputs,
// but their effect first shows up on the following clock edge.

module clock_group_reset_sequencer #(
    parameter int N_MEMBERS   = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_MEMBERS-1:0] io_member_en,
    input  logic                 io_req_assert,
    output logic [N_MEMBERS-1:0] io_out_reset,
    output logic [N_MEMBERS-1:0] io_out_clock_en,
    output logic [1:0]           io_state,
    output logic                 io_busy,
    output logic                 io_done
);

    localparam int MAX_COUNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W     = $clog2(MAX_COUNT + 1);
    localparam int IDX_W     = (N_MEMBERS > 1) ? $clog2(N_MEMBERS) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2,
        ST_QUIESCE = 2'd3
    } state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } hit_t;

    // Lowest set bit of mask at or above start.
    function automatic hit_t lowest_from(input logic [N_MEMBERS-1:0] mask, input int start);
        hit_t h;
        h = '0;
        for (int i = N_MEMBERS - 1; i >= 0; i--) begin
            if (mask[i] && (i >= start)) begin
                h.found = 1'b1;
                h.idx   = IDX_W'(i);
            end
        end
        return h;
    endfunction

    // Any set bit of mask at or above start.
    function automatic logic any_from(input logic [N_MEMBERS-1:0] mask, input int start);
        logic any;
        any = 1'b0;
        for (int i = 0; i < N_MEMBERS; i++) begin
            if (mask[i] && (i >= start)) begin
                any = 1'b1;
            end
        end
        return any;
    endfunction

    // Highest set bit of mask strictly below limit.
    function automatic hit_t highest_below(input logic [N_MEMBERS-1:0] mask, input int limit);
        hit_t h;
        h = '0;
        for (int i = 0; i < N_MEMBERS; i++) begin
            if (mask[i] && (i < limit)) begin
                h.found = 1'b1;
                h.idx   = IDX_W'(i);
            end
        end
        return h;
    endfunction

    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [IDX_W-1:0]     idx, idx_n;
    logic [N_MEMBERS-1:0] nxt_reset;
    logic [N_MEMBERS-1:0] nxt_clock_en;
    logic                 nxt_busy;
    logic                 nxt_done;

    // Release search: from HOLD the walk starts at member 0, inside RELEASE
    // it continues just above the member released last.
    int                   rel_start;
    hit_t                 rel_pick;
    logic                 rel_more;
    logic                 do_release;

    // Quiesce search: only members that are enabled and still out of reset
    // need asserting; everything else already sits in reset.
    logic [N_MEMBERS-1:0] q_cand;
    int                   q_limit;
    hit_t                 q_pick;

    always_comb begin
        rel_start = (state == ST_HOLD) ? 0 : int'(idx) + 1;
        rel_pick  = lowest_from(io_member_en, rel_start);
        rel_more  = any_from(io_member_en, int'(rel_pick.idx) + 1);
        q_cand    = io_member_en & ~io_out_reset;
        q_limit   = (state == ST_RUN) ? N_MEMBERS : int'(idx);
        q_pick    = highest_below(q_cand, q_limit);
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        idx_n        = idx;
        nxt_reset    = io_out_reset;
        nxt_clock_en = '1;
        nxt_done     = 1'b0;
        do_release   = 1'b0;

        case (state)
            ST_HOLD: begin
                nxt_reset = '1;
                if (cnt == HOLD_LAST) begin
                    cnt_n      = '0;
                    do_release = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end

            ST_RELEASE: begin
                if (io_req_assert) begin
                    // Abort: everything back into reset, full hold restarts.
                    state_n   = ST_HOLD;
                    cnt_n     = '0;
                    idx_n     = '0;
                    nxt_reset = '1;
                end else if (cnt == GAP_LAST) begin
                    cnt_n      = '0;
                    do_release = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end

            ST_RUN: begin
                // A dropped enable forces that member into reset; a rising
                // enable cannot lift it until the next release sequence.
                nxt_reset    = io_out_reset | ~io_member_en;
                nxt_clock_en = io_member_en & ~nxt_reset;
                if (io_req_assert) begin
                    state_n      = ST_QUIESCE;
                    cnt_n        = '0;
                    nxt_clock_en = '1;
                    idx_n        = q_pick.found ? q_pick.idx : '0;
                    if (q_pick.found) begin
                        nxt_reset[q_pick.idx] = 1'b1;
                    end
                end
            end

            ST_QUIESCE: begin
                if (cnt == GAP_LAST) begin
                    cnt_n = '0;
                    if (q_pick.found) begin
                        nxt_reset[q_pick.idx] = 1'b1;
                        idx_n                 = q_pick.idx;
                    end else begin
                        state_n   = ST_HOLD;
                        idx_n     = '0;
                        nxt_reset = '1;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end

            default: begin
                state_n   = ST_HOLD;
                cnt_n     = '0;
                idx_n     = '0;
                nxt_reset = '1;
            end
        endcase

        // One release step, shared by the end of HOLD and each gap end in
        // RELEASE. Releasing the last enabled member (or finding none at all)
        // enters RUN on the same edge.
        if (do_release) begin
            if (rel_pick.found) begin
                nxt_reset[rel_pick.idx] = 1'b0;
                idx_n                   = rel_pick.idx;
            end
            if (rel_pick.found && rel_more) begin
                state_n = ST_RELEASE;
            end else begin
                state_n      = ST_RUN;
                nxt_done     = 1'b1;
                nxt_clock_en = io_member_en & ~nxt_reset;
            end
        end

        nxt_busy = (state_n != ST_RUN);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= ST_HOLD;
            cnt             <= '0;
            idx             <= '0;
            io_out_reset    <= '1;
            io_out_clock_en <= '1;
            io_busy         <= 1'b1;
            io_done         <= 1'b0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            idx             <= idx_n;
            io_out_reset    <= nxt_reset;
            io_out_clock_en <= nxt_clock_en;
            io_busy         <= nxt_busy;
            io_done         <= nxt_done;
        end
    end

    assign io_state = state;

endmodule

// File: doc/clock_group_reset_sequencer.md
CLOCK_GROUP_RESET_SEQUENCER -- requirements
Module: clock_group_reset_sequencer

Interface
REQ-001 Parameter N_MEMBERS, default 4, number of clock-group members sequenced (1..32).
REQ-002 Parameter HOLD_CYCLES, default 16, minimum cycles all member resets stay asserted (>=1).
REQ-003 Parameter GAP_CYCLES, default 8, cycles between consecutive member release/assert steps (>=1).
REQ-004 clock  input  1  single clock for all logic.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 io_member_en  input  N_MEMBERS  per-member enable mask; bit i=0 keeps member i in reset.
REQ-007 io_req_assert  input  1  request to re-enter reset; level, sampled each cycle.
REQ-008 io_out_reset  output  N_MEMBERS  per-member synchronous reset to the member domains, active-high.
REQ-009 io_out_clock_en  output  N_MEMBERS  per-member clock enable.
REQ-010 io_state  output  2  FSM state: 0 HOLD, 1 RELEASE, 2 RUN, 3 QUIESCE.
REQ-011 io_busy  output  1  high in HOLD, RELEASE and QUIESCE.
REQ-012 io_done  output  1  one-cycle pulse when RUN is entered.

Function
REQ-013 All outputs SHALL be registered; no combinational input-to-output path.
REQ-014 Cycle numbering: cycle 1 is the first cycle with reset low.
REQ-015 HOLD: io_out_reset all ones, io_out_clock_en all ones, counter counts HOLD_CYCLES cycles, then RELEASE with idx=0.
REQ-016 RELEASE: on entry to step idx, member idx is released (io_out_reset[idx]=0) if io_member_en[idx]=1; the next step follows GAP_CYCLES cycles later.
REQ-017 RELEASE: a disabled member is skipped with no gap; the next enabled member is released in the same cycle the skipped member would have been.
REQ-018 The edge that releases the last enabled member SHALL also enter RUN and pulse io_done; with no member enabled, RUN is entered directly from HOLD with io_done pulsed.
REQ-019 RUN: io_out_clock_en[i]=io_member_en[i], registered one cycle; a member whose enable falls gets io_out_reset[i]=1 the next cycle; a rising enable has no effect until the next release sequence.
REQ-020 io_req_assert=1 in RUN: enter QUIESCE; assert enabled member resets in reverse order (N_MEMBERS-1 down to 0), first one on the entry edge, GAP_CYCLES apart, disabled members skipped with no gap; after the last assertion plus GAP_CYCLES, enter HOLD.
REQ-021 io_req_assert=1 in RELEASE: next cycle all io_out_reset=1 and HOLD restarts with a full HOLD_CYCLES count.
REQ-022 io_req_assert in HOLD or QUIESCE SHALL be ignored; io_req_assert still high when RUN is entered SHALL trigger QUIESCE on the next edge.
REQ-023 io_out_clock_en SHALL be all ones in HOLD, RELEASE and QUIESCE, so member synchronous resets propagate.
REQ-024 Counter width SHALL be ceil(log2(max(HOLD_CYCLES,GAP_CYCLES)+1)) bits; no wrap-around during a count.

Reset
REQ-025 reset=1 at an edge: next cycle state=HOLD, counter=0, idx=0, io_out_reset all ones, io_out_clock_en all ones, io_busy=1, io_done=0; this holds from any state, including mid-RELEASE and mid-QUIESCE.
REQ-026 The sequence restarts from cycle 1 on every reset deassertion.

Verification (N_MEMBERS=4, HOLD_CYCLES=16, GAP_CYCLES=8)
REQ-027 Release, member_en=1111 -> io_out_reset 1110@17, 1100@25, 1000@33, 0000@41; io_done=1 and io_state=2 only @41; io_busy=0 from 41.
REQ-028 Skip, member_en=1010 -> bit1 low @17, bit3 low @25; io_done @25; io_out_reset stays 0101 in RUN; io_out_clock_en=1010 in RUN.
REQ-029 io_req_assert=1 for one cycle in RUN @60, member_en=1111 -> io_state=3 @61; io_out_reset 1000@61, 1100@69, 1110@77, 1111@85; HOLD @93; bit0 low again @109.
REQ-030 Abort, io_req_assert=1 @28 during RELEASE -> io_out_reset=1111 @29, HOLD restarts; bit0 low @45.
REQ-031 Mask drop, io_member_en[2] cleared @50 in RUN -> io_out_reset[2]=1 and io_out_clock_en[2]=0 @51; re-set @55 leaves both unchanged.
REQ-032 reset=1 @35 mid-RELEASE -> @36 io_out_reset=1111, io_state=0, io_done=0; after deassertion the release timing of REQ-027 repeats.
